// File: rtl/gfx_bus_pkg.sv
// gfx_bus_pkg: shared definitions for the graphics device bus.
//   - bus word field positions and widths
//   - IDLE_WORD, the value the bus carries when nothing is issued
//   - issuer FSM state enum
//   - graphics opcode constants
//   - bus_word(): builds a tagged bus word from a device address and command
package gfx_bus_pkg;

  localparam int BUS_W        = 32;
  localparam int CMD_W        = 24;
  localparam int BUS_ADDR_MSB = 31;
  localparam int BUS_ADDR_LSB = 30;
  localparam int BUS_CMD_MSB  = 23;
  localparam int BUS_CMD_LSB  = 0;

  localparam logic [BUS_W-1:0] IDLE_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_GAP      = 2'd2,
    ST_WAIT_IRQ = 2'd3
  } gfx_state_e;

  // Graphics opcodes (upper byte of a command)
  localparam logic [7:0] OP_PAL_SEL       = 8'd3;
  localparam logic [7:0] OP_PAL_DATA_LO   = 8'd4;
  localparam logic [7:0] OP_PAL_DATA_HI   = 8'd5;
  localparam logic [7:0] OP_TEX_FIRST     = 8'd6;
  localparam logic [7:0] OP_TEX_LAST      = 8'd9;
  localparam logic [7:0] OP_BLK_FIRST     = 8'd10;
  localparam logic [7:0] OP_BLK_LAST      = 8'd13;
  localparam logic [7:0] OP_UI_FIRST      = 8'd14;
  localparam logic [7:0] OP_UI_LAST       = 8'd17;
  localparam logic [7:0] OP_SPR_FIRST     = 8'd18;
  localparam logic [7:0] OP_SPR_LAST      = 8'd21;
  localparam logic [7:0] OP_SPR_CTL_FIRST = 8'd22;
  localparam logic [7:0] OP_SPR_CTL_LAST  = 8'd33;

  // {addr, 6'b0, cmd}; bits [29:24] are always zero on this bus.
  function automatic logic [BUS_W-1:0] bus_word(input logic [1:0] addr,
                                                input logic [CMD_W-1:0] cmd);
    logic [BUS_W-1:0] w;
    w = IDLE_WORD;
    w[BUS_ADDR_MSB:BUS_ADDR_LSB] = addr;
    w[BUS_CMD_MSB:BUS_CMD_LSB]   = cmd;
    return w;
  endfunction

endpackage

// File: rtl/gfx_cmd_fifo.sv
// gfx_cmd_fifo: synchronous DEPTH-deep FIFO (DEPTH a power of two).
//   clk, rst (async active-low)
//   push/wdata : write when not full and not flushing
//   pop/rdata  : rdata shows the head; pop advances when not empty and not flushing
//   flush      : synchronous discard of all entries (wins over push and pop)
//   level      : occupancy 0..DEPTH; full/empty derived from it
module gfx_cmd_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 25,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  input  logic             flush,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/gfx_cmd_issuer.sv
// gfx_cmd_issuer: queues graphics commands and wait-for-irq markers and
// issues commands onto the device bus as {DEVADDR, 6'b0, cmd} words.
//   clk, rst (async active-low)
//   cmd_in/cmd_wait/cmd_valid/cmd_ready : entry source handshake
//   flush     : drop every queued entry, return to IDLE, bus idle next cycle
//   irq       : level interrupt; a rising edge releases WAIT_IRQ
//   out       : registered bus word, IDLE_WORD when not issuing
//   busy      : queue non-empty or FSM not idle
//   level     : queue occupancy
//   dbg_state : current FSM state
//
// Handshake: an entry transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; cmd_ready depends only on the registered level
// (never on cmd_valid), and the source must hold the entry until it transfers.
// A push coincident with flush is dropped even though cmd_ready was high.
module gfx_cmd_issuer
  import gfx_bus_pkg::*;
#(
  parameter  int         DEPTH   = 16,
  parameter  logic [1:0] DEVADDR = 2'd2,   // 2'd0 is the bus idle address; do not use
  parameter  int         MIN_GAP = 0,      // 0..15 idle cycles after each word
  localparam int         LW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CMD_W-1:0] cmd_in,
  input  logic             cmd_wait,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             flush,
  input  logic             irq,
  output logic [BUS_W-1:0] out,
  output logic             busy,
  output logic [LW-1:0]    level,
  output gfx_state_e       dbg_state
);

  logic [CMD_W:0] head;        // {wait, cmd}
  logic           fifo_full;
  logic           fifo_empty;
  logic           take;
  gfx_state_e     state;
  logic [3:0]     gap_cnt;
  logic           irq_q;

  gfx_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .wdata ({cmd_wait, cmd_in}),
    .pop   (take),
    .rdata (head),
    .flush (flush),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd_ready = !fifo_full;
  assign busy      = !fifo_empty || (state != ST_IDLE);
  assign dbg_state = state;

  // Points where the FSM may consume the head entry. The last gap cycle
  // dispatches directly so words are exactly MIN_GAP+1 cycles apart.
  always_comb begin
    take = 1'b0;
    if (!flush && !fifo_empty) begin
      case (state)
        ST_IDLE:  take = 1'b1;
        ST_ISSUE: take = (MIN_GAP == 0);
        ST_GAP:   take = (gap_cnt == 4'd1);
        default:  take = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      out     <= IDLE_WORD;
      gap_cnt <= '0;
      irq_q   <= 1'b0;
    end else begin
      irq_q <= irq;
      if (flush) begin
        state   <= ST_IDLE;
        out     <= IDLE_WORD;
        gap_cnt <= '0;
      end else if (take) begin
        gap_cnt <= '0;
        if (head[CMD_W]) begin
          // Wait marker: no bus cycle, no gap.
          state <= ST_WAIT_IRQ;
          out   <= IDLE_WORD;
        end else begin
          state <= ST_ISSUE;
          out   <= bus_word(DEVADDR, head[CMD_W-1:0]);
        end
      end else begin
        out <= IDLE_WORD;
        case (state)
          ST_IDLE: state <= ST_IDLE;
          ST_ISSUE: begin
            if (MIN_GAP != 0) begin
              state   <= ST_GAP;
              gap_cnt <= 4'(MIN_GAP);
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_GAP: begin
            if (gap_cnt <= 4'd1) begin
              state   <= ST_IDLE;
              gap_cnt <= '0;
            end else begin
              gap_cnt <= gap_cnt - 4'd1;
            end
          end
          ST_WAIT_IRQ: begin
            // Only an edge seen while waiting releases; a level already
            // high on entry has irq_q high too.
            if (irq && !irq_q) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gfx_cmd_issuer.sv
// tb_gfx_cmd_issuer: directed bench for gfx_cmd_issuer. Instance a uses
// MIN_GAP=0, instance b uses MIN_GAP=2; both share clk and rst.
module tb_gfx_cmd_issuer;
  import gfx_bus_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // instance a (MIN_GAP=0)
  logic [23:0] a_cmd = '0;
  logic        a_wait = 1'b0, a_valid = 1'b0, a_flush = 1'b0, a_irq = 1'b0;
  logic        a_ready, a_busy;
  logic [31:0] a_out;
  logic [4:0]  a_level;
  gfx_state_e  a_state;

  // instance b (MIN_GAP=2)
  logic [23:0] b_cmd = '0;
  logic        b_wait = 1'b0, b_valid = 1'b0, b_flush = 1'b0, b_irq = 1'b0;
  logic        b_ready, b_busy;
  logic [31:0] b_out;
  logic [4:0]  b_level;
  gfx_state_e  b_state;

  gfx_cmd_issuer #(.DEPTH(16), .DEVADDR(2'd2), .MIN_GAP(0)) dut_a (
    .clk(clk), .rst(rst), .cmd_in(a_cmd), .cmd_wait(a_wait), .cmd_valid(a_valid),
    .cmd_ready(a_ready), .flush(a_flush), .irq(a_irq), .out(a_out),
    .busy(a_busy), .level(a_level), .dbg_state(a_state)
  );

  gfx_cmd_issuer #(.DEPTH(16), .DEVADDR(2'd2), .MIN_GAP(2)) dut_b (
    .clk(clk), .rst(rst), .cmd_in(b_cmd), .cmd_wait(b_wait), .cmd_valid(b_valid),
    .cmd_ready(b_ready), .flush(b_flush), .irq(b_irq), .out(b_out),
    .busy(b_busy), .level(b_level), .dbg_state(b_state)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] gap_exp [11];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // All driving and sampling happens 1 ns after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_of(input logic [23:0] c);
    return {2'd2, 6'd0, c};
  endfunction

  initial begin
    // reset
    tick();
    tick();
    rst = 1'b1;
    check("rst_out",   a_out, 32'h0);
    check("rst_busy",  32'(a_busy), 32'd0);
    check("rst_level", 32'(a_level), 32'd0);
    check("rst_ready", 32'(a_ready), 32'd1);
    check("rst_state", 32'(a_state), 32'(ST_IDLE));

    // single command latency and duration
    a_valid = 1'b1; a_wait = 1'b0; a_cmd = {8'd3, 16'd15};
    tick();                                    // accepted
    a_valid = 1'b0;
    check("single_acc_out", a_out, 32'h0);
    check("single_acc_lvl", 32'(a_level), 32'd1);
    tick();
    check("single_word", a_out, 32'h8003000F);
    check("single_busy_hi", 32'(a_busy), 32'd1);
    tick();
    check("single_after", a_out, 32'h0);
    check("single_busy_lo", 32'(a_busy), 32'd0);

    // MIN_GAP=2: three back-to-back pushes, words 3 cycles apart
    gap_exp = '{32'h0, 32'h80100001, 32'h0, 32'h0, 32'h80100002, 32'h0, 32'h0,
                32'h80100003, 32'h0, 32'h0, 32'h0};
    b_valid = 1'b1; b_wait = 1'b0; b_cmd = 24'h100001;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (i == 0) b_cmd = 24'h100002;
      else if (i == 1) b_cmd = 24'h100003;
      else b_valid = 1'b0;
      check($sformatf("gap_seq[%0d]", i), b_out, gap_exp[i]);
    end
    check("gap_busy_lo", 32'(b_busy), 32'd0);

    // fill 16 entries behind a wait marker
    a_valid = 1'b1; a_wait = 1'b1; a_cmd = 24'h0;
    tick();
    a_wait = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a_cmd = {8'd18, 16'h0100 + 16'(i)};
      tick();
    end
    check("full_level", 32'(a_level), 32'd16);
    check("full_ready", 32'(a_ready), 32'd0);
    check("full_state", 32'(a_state), 32'(ST_WAIT_IRQ));
    a_cmd = 24'hEEEEEE;                        // 17th offer
    tick();
    a_valid = 1'b0;
    check("full_17th_level", 32'(a_level), 32'd16);
    check("full_out_idle", a_out, 32'h0);
    a_irq = 1'b1;
    tick();                                    // rising edge sampled
    check("full_rel_out0", a_out, 32'h0);
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("full_word[%0d]", i), a_out, word_of({8'd18, 16'h0100 + 16'(i)}));
    end
    tick();
    check("full_drain_out", a_out, 32'h0);
    check("full_drain_busy", 32'(a_busy), 32'd0);

    // A, marker, B with irq held high: B waits for a fresh edge
    a_valid = 1'b1; a_wait = 1'b0; a_cmd = 24'h0E1234;
    tick();
    a_wait = 1'b1; a_cmd = 24'h0;
    tick();
    check("wait_a_word", a_out, 32'h800E1234);
    a_wait = 1'b0; a_cmd = 24'h0F5678;
    tick();
    a_valid = 1'b0;
    check("wait_after_a", a_out, 32'h0);
    tick();
    tick();
    check("wait_hold_out", a_out, 32'h0);
    check("wait_hold_lvl", 32'(a_level), 32'd1);
    a_irq = 1'b0;
    tick();
    tick();
    check("wait_low_out", a_out, 32'h0);
    a_irq = 1'b1;
    tick();                                    // edge j
    check("wait_edge_out", a_out, 32'h0);
    tick();                                    // edge j+1
    check("wait_b_word", a_out, 32'h800F5678);
    tick();
    check("wait_b_after", a_out, 32'h0);
    check("wait_b_busy", 32'(a_busy), 32'd0);

    // flush in GAP with 5 queued plus a simultaneous push
    b_valid = 1'b1; b_wait = 1'b0;
    for (int i = 0; i < 7; i++) begin
      b_cmd = {8'd22, 16'(i)};
      tick();
    end
    check("flush_pre_level", 32'(b_level), 32'd5);
    check("flush_pre_state", 32'(b_state), 32'(ST_GAP));
    b_flush = 1'b1; b_cmd = 24'hABCDEF;
    tick();
    b_flush = 1'b0; b_valid = 1'b0;
    check("flush_level", 32'(b_level), 32'd0);
    check("flush_out", b_out, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("flush_quiet[%0d]", i), b_out, 32'h0);
    end
    check("flush_busy", 32'(b_busy), 32'd0);

    // asynchronous reset in the middle of issuing
    a_valid = 1'b1; a_wait = 1'b0; a_cmd = 24'h0A0001;
    tick();
    a_cmd = 24'h0A0002;
    tick();
    a_cmd = 24'h0A0003;
    tick();
    a_valid = 1'b0;
    check("mid_word", a_out, 32'h800A0002);
    check("mid_level", 32'(a_level), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_out", a_out, 32'h0);
    check("arst_level", 32'(a_level), 32'd0);
    check("arst_ready", 32'(a_ready), 32'd1);
    check("arst_busy", 32'(a_busy), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    a_valid = 1'b1; a_cmd = 24'h157777;
    tick();
    a_valid = 1'b0;
    check("post_rst_acc", a_out, 32'h0);
    tick();
    check("post_rst_word", a_out, 32'h80157777);
    tick();
    check("post_rst_after", a_out, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gfx_cmd_issuer.md
# gfx_cmd_issuer

- Host-side initiator for the 32-bit device bus that feeds the graphics connector.
- Buffers 24-bit graphics commands ({opcode[7:0], data[15:0]}) in a FIFO and emits them as bus words tagged with the graphics device address.
- Enforces a programmable inter-word gap and supports wait-for-irq markers, so a command stream can be synchronised to the graphics engine's interrupt.
- Sits between the CPU/DMA command source and the bus input of the graphics subsystem.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of two, 2..256.
- DEVADDR, 2'd2: device address placed in bus bits [31:30]. 2'd0 is reserved as the bus idle address and is illegal here.
- MIN_GAP, 0: idle bus cycles forced after each emitted word, 0..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- cmd_in  in  24  command {opcode, data}; ignored when cmd_wait=1.
- cmd_wait  in  1  entry is a wait-for-irq marker, not a bus command.
- cmd_valid  in  1  source offers an entry.
- cmd_ready  out  1  FIFO can accept an entry.
- flush  in  1  synchronous discard of all queued entries.
- irq  in  1  interrupt from the graphics engine, level, synchronous to clk.
- out  out  32  bus word: {DEVADDR, 6'b0, cmd} when issuing, 32'h0 when idle.
- busy  out  1  FIFO non-empty or FSM not in IDLE.
- level  out  $clog2(DEPTH+1)  current FIFO occupancy.

## Operation
- Push: an entry {cmd_wait, cmd_in} is written on a clk edge where cmd_valid && cmd_ready. cmd_ready = (level != DEPTH).
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop the head. A command entry drives out with it for the next cycle and goes to ISSUE. A wait entry goes to WAIT_IRQ with out=0.
  - ISSUE: out holds the word for exactly one cycle. Then:
    - MIN_GAP>0: go to GAP with the counter loaded to MIN_GAP.
    - MIN_GAP=0, FIFO non-empty: pop the next entry directly (back-to-back words).
    - MIN_GAP=0, FIFO empty: go to IDLE.
  - GAP: out=0; decrement the counter; at 1, go to IDLE.
  - WAIT_IRQ: out=0. irq is sampled each cycle into irq_q. A rising edge (irq && !irq_q) observed while in WAIT_IRQ returns to IDLE. irq already high on entry does not count.
- A wait marker consumes no bus cycle and no gap.
- flush:
  - FIFO emptied (level=0).
  - FSM to IDLE.
  - The next-cycle out is 0.
  - A push in the same cycle is discarded.
  - flush overrides every state, including WAIT_IRQ and GAP.
- Simultaneous push and pop:
  - Allowed when not full. level is unchanged.
  - When full, cmd_ready=0, so a same-cycle pop does not enable a push.
- Pointers wrap modulo DEPTH; level counts 0..DEPTH.

## Timing
- Reset values:
  - out=32'h0, busy=0, level=0, cmd_ready=1.
  - FSM=IDLE, irq_q=0, gap counter=0, FIFO pointers=0.
- Reset asserted mid-stream clears everything immediately (asynchronous). No partial word remains on out.
- Latency: an entry accepted into an empty FIFO at edge k appears on out from edge k+1 to edge k+2.
- Throughput:
  - MIN_GAP=0: one word per cycle.
  - Otherwise: one word per MIN_GAP+1 cycles.
- Wait release: an irq rising edge sampled at edge j has the next queued word on out from edge j+1 to edge j+2.
- out is registered; no combinational path from any input to out. cmd_ready depends only on registered level.

## Structure
- Package gfx_bus_pkg holds:
  - bus field positions (ADDR [31:30], CMD [23:0]);
  - IDLE_WORD=32'h0;
  - the FSM state enum;
  - graphics opcode constants (palette select 3, palette data 4/5, texture 6–9, block 10–13, UI 14–17, sprite 18–21, sprite control 22–33).
- One sub-module, gfx_cmd_fifo: synchronous 25-bit wide, DEPTH-deep FIFO with push, pop, flush, level, full and empty outputs.

## Test plan
- After reset, push {8'd3,16'd15} once → out=32'h8003000F (DEVADDR=2) for exactly one cycle, starting one cycle after accept; then 32'h0; busy falls.
- MIN_GAP=2, push 3 commands back-to-back → words spaced exactly 3 cycles apart; out=0 in each gap.
- Fill DEPTH=16 without popping (held in WAIT_IRQ) → level=16, cmd_ready=0; a 17th cmd_valid is not accepted; after the irq edge, 16 words are emitted in order.
- Queue cmd A, wait marker, cmd B with irq held high → A is emitted, B is held; drop irq then raise it → B is emitted one cycle after the sampled rising edge.
- flush while in GAP with 5 entries queued, with a simultaneous push → level=0, out=0 next cycle, no further words, pushed entry lost.
- Assert rst mid-issue → out=0 immediately, level=0, cmd_ready=1; a fresh push after release emits normally.
